// File: rtl/aq_gemac_pkg.sv
// Shared types and constants for the GEMAC TX/RX arbitration blocks.
package aq_gemac_pkg;

    localparam int unsigned LEN_W           = 16;
    localparam int unsigned NEED_W          = 17;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned SPACE_W         = 10;
    localparam int unsigned FRAME_HDR_BYTES = 4;

    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_CHECK   = 2'd1,
        A_GRANT   = 2'd2,
        A_RELEASE = 2'd3
    } arb_state_e;

    // Buffer bytes a frame occupies, including its leading length word.
    function automatic logic [NEED_W-1:0] frame_need(input logic [LEN_W-1:0] len);
        return NEED_W'(len) + NEED_W'(FRAME_HDR_BYTES);
    endfunction

    // Free buffer space converted from 32-bit words to bytes.
    function automatic logic [NEED_W-1:0] space_bytes(input logic [SPACE_W-1:0] words);
        return {5'd0, words, 2'd0};
    endfunction

endpackage

// File: rtl/aq_gemac_tx_arbiter_if.sv
// Request/write bus between frame sources, the TX arbiter and the MAC TX buffer.
interface aq_gemac_tx_arbiter_if
    import aq_gemac_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]        req;
    logic [LEN_W*NREQ-1:0]  req_len;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        src_we;
    logic [NREQ-1:0]        src_start;
    logic [NREQ-1:0]        src_end;
    logic [DATA_W*NREQ-1:0] src_data;
    logic                   tx_we;
    logic                   tx_start;
    logic                   tx_end;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_ready;
    logic                   tx_full;
    logic [SPACE_W-1:0]     tx_space;

    // Arbiter side; tx_full goes straight to the sources and is not arbitrated.
    modport master (
        input  req, req_len, src_we, src_start, src_end, src_data,
        input  tx_ready, tx_space,
        output gnt, tx_we, tx_start, tx_end, tx_data
    );

    // Sources plus MAC buffer side.
    modport slave (
        output req, req_len, src_we, src_start, src_end, src_data,
        output tx_ready, tx_full, tx_space,
        input  gnt, tx_we, tx_start, tx_end, tx_data
    );

endinterface

// File: rtl/aq_gemac_rr_pick.sv
// Combinational rotating-priority encoder: first requester after i_ptr wins.
module aq_gemac_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    int unsigned w_pos;

    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_pos     = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            w_pos = 32'(i_ptr) + off;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!o_valid_c && i_req[IDX_W'(w_pos)]) begin
                o_valid_c = 1'b1;
                o_idx_c   = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/aq_gemac_tx_arbiter.sv
// Frame-atomic round-robin arbiter for the single MAC TX buffer write port.
module aq_gemac_tx_arbiter
    import aq_gemac_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WDOG = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    aq_gemac_tx_arbiter_if.master bus,
    output logic                  o_busy,
    output logic                  o_err_wdog,
    output logic                  o_err_proto,
    input  logic                  i_err_clr
);

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDOG_W = $clog2(WDOG);

    arb_state_e          r_state, w_state_nxt;
    logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [NEED_W-1:0]   r_need, w_need_nxt;
    logic [WDOG_W-1:0]   r_idle, w_idle_nxt;
    logic                r_first, w_first_nxt;
    logic                r_err_wdog, r_err_proto;

    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_valid;
    logic [LEN_W-1:0]    w_pick_len;
    logic                w_sel_req, w_sel_we, w_sel_start, w_sel_end;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_granted, w_fwd_we, w_wdog_fire, w_stray, w_proto_set;

    aq_gemac_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    // Per-source selection for the latched owner and for the current pick.
    always_comb begin
        w_sel_req   = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_start = 1'b0;
        w_sel_end   = 1'b0;
        w_sel_data  = '0;
        w_pick_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_req   = bus.req[i];
                w_sel_we    = bus.src_we[i];
                w_sel_start = bus.src_start[i];
                w_sel_end   = bus.src_end[i];
                w_sel_data  = bus.src_data[DATA_W*i +: DATA_W];
            end
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_len = bus.req_len[LEN_W*i +: LEN_W];
            end
        end
    end

    // A frame must open with START; a headless first write is dropped.
    assign w_granted = (r_state == A_GRANT);
    assign w_fwd_we  = w_granted && w_sel_we && !(r_first && !w_sel_start);

    assign bus.tx_we    = w_fwd_we;
    assign bus.tx_start = w_granted && w_sel_start;
    assign bus.tx_end   = w_granted && w_sel_end;
    assign bus.tx_data  = w_granted ? w_sel_data : '0;
    assign bus.gnt      = r_gnt;

    assign o_busy      = (r_state != A_IDLE);
    assign o_err_wdog  = r_err_wdog;
    assign o_err_proto = r_err_proto;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_need_nxt  = r_need;
        w_idle_nxt  = r_idle;
        w_first_nxt = r_first;
        w_wdog_fire = 1'b0;
        case (r_state)
            A_IDLE: begin
                if (w_pick_valid) begin
                    w_idx_nxt   = w_pick_idx;
                    w_need_nxt  = frame_need(w_pick_len);
                    w_state_nxt = A_CHECK;
                end
            end
            // No re-arbitration here, so a large frame waits for room without being starved.
            A_CHECK: begin
                if (!w_sel_req) begin
                    w_state_nxt = A_IDLE;
                end else if (bus.tx_ready && (space_bytes(bus.tx_space) > r_need)) begin
                    w_state_nxt = A_GRANT;
                    w_gnt_nxt   = NREQ'(1) << r_idx;
                    w_idle_nxt  = '0;
                    w_first_nxt = 1'b1;
                end
            end
            A_GRANT: begin
                if (w_sel_we) begin
                    w_idle_nxt = '0;
                    if (w_fwd_we) begin
                        w_first_nxt = 1'b0;
                    end
                    if (w_sel_end) begin
                        w_state_nxt = A_RELEASE;
                        w_gnt_nxt   = '0;
                    end
                end else if (r_idle == WDOG_W'(WDOG - 1)) begin
                    w_wdog_fire = 1'b1;
                    w_state_nxt = A_RELEASE;
                    w_gnt_nxt   = '0;
                end else begin
                    w_idle_nxt = r_idle + WDOG_W'(1);
                end
            end
            A_RELEASE: begin
                w_gnt_nxt   = '0;
                w_ptr_nxt   = r_idx;
                w_state_nxt = A_IDLE;
            end
            default: begin
                w_state_nxt = A_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= A_IDLE;
            r_gnt   <= '0;
            r_ptr   <= IDX_W'(NREQ - 1);
            r_idx   <= '0;
            r_need  <= '0;
            r_idle  <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_need  <= w_need_nxt;
            r_idle  <= w_idle_nxt;
            r_first <= w_first_nxt;
        end
    end

    // Stray writes, a headless first write, or a repeated START within one grant.
    assign w_stray     = |(bus.src_we & ~r_gnt);
    assign w_proto_set = w_stray
                       | (w_granted & w_sel_we &  r_first & ~w_sel_start)
                       | (w_granted & w_sel_we & ~r_first &  w_sel_start);

    // Sticky error flags; a same-cycle set wins over clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_wdog  <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            if (w_wdog_fire) begin
                r_err_wdog <= 1'b1;
            end else if (i_err_clr) begin
                r_err_wdog <= 1'b0;
            end
            if (w_proto_set) begin
                r_err_proto <= 1'b1;
            end else if (i_err_clr) begin
                r_err_proto <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aq_gemac_tx_arbiter.sv
// Directed self-checking bench for aq_gemac_tx_arbiter (NREQ=4, WDOG=16).
module tb_aq_gemac_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned WDOG = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic busy, err_wdog, err_proto;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aq_gemac_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    aq_gemac_tx_arbiter #(
        .NREQ (NREQ),
        .WDOG (WDOG)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_busy      (busy),
        .o_err_wdog  (err_wdog),
        .o_err_proto (err_proto),
        .i_err_clr   (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic src_idle();
        bus.src_we    = '0;
        bus.src_start = '0;
        bus.src_end   = '0;
        bus.src_data  = '0;
    endtask

    task automatic src_wr(input int s, input logic st, input logic en, input logic [31:0] d);
        src_idle();
        bus.src_we[s]             = 1'b1;
        bus.src_start[s]          = st;
        bus.src_end[s]            = en;
        bus.src_data[32*s +: 32]  = d;
    endtask

    task automatic wait_gnt(input int max_cyc, output int cyc);
        cyc = 0;
        while (bus.gnt == '0 && cyc < max_cyc) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int  cyc;
        logic saw;

        rst_n        = 1'b0;
        err_clr      = 1'b0;
        bus.req      = '0;
        bus.req_len  = '0;
        src_idle();
        bus.tx_ready = 1'b1;
        bus.tx_full  = 1'b0;
        bus.tx_space = 10'd100;
        repeat (3) step();

        check_eq("rst_gnt", bus.gnt, 0);
        check_eq("rst_tx_we", bus.tx_we, 0);
        check_eq("rst_tx_data", bus.tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_errs", {err_wdog, err_proto}, 0);
        rst_n = 1'b1;
        step();

        // single source, 64-byte frame = 17 words
        bus.req_len[15:0] = 16'd64;
        bus.req[0]        = 1'b1;
        step();
        check_eq("t1_gnt_c1", bus.gnt, 0);
        check_eq("t1_busy", busy, 1);
        step();
        check_eq("t1_gnt_c2", bus.gnt, 4'b0001);
        bus.req[0] = 1'b0;
        for (int w = 0; w < 17; w++) begin
            src_wr(0, w == 0, w == 16, 32'hA500_0000 + 32'(w));
            #1;
            check_eq("t1_we", bus.tx_we, 1);
            check_eq("t1_start", bus.tx_start, (w == 0) ? 1 : 0);
            check_eq("t1_end", bus.tx_end, (w == 16) ? 1 : 0);
            check_eq("t1_data", bus.tx_data, 32'hA500_0000 + 32'(w));
            step();
        end
        check_eq("t1_gnt_fall", bus.gnt, 0);
        src_idle();
        #1;
        check_eq("t1_we_after", bus.tx_we, 0);
        check_eq("t1_no_proto", err_proto, 0);
        step();

        // round robin from reset: 0,1,2,3,0 with 3-cycle gaps
        do_reset();
        bus.req_len = '0;
        bus.req     = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(10, cyc);
            check_eq("rr_gap", cyc, (k == 0) ? 2 : 3);
            check_eq("rr_gnt", bus.gnt, 32'(1) << (k % 4));
            src_wr(k % 4, 1'b1, 1'b1, 32'hB000_0000 + 32'(k));
            #1;
            check_eq("rr_data", bus.tx_data, 32'hB000_0000 + 32'(k));
            step();
            src_idle();
        end
        bus.req = '0;
        step();
        step();

        // space gating: 404 bytes needed, 101 words is not enough
        bus.req_len[31:16] = 16'd400;
        bus.tx_space       = 10'd101;
        bus.req[1]         = 1'b1;
        repeat (4) step();
        check_eq("space_eq_blk", bus.gnt, 0);
        check_eq("space_busy", busy, 1);
        bus.tx_space = 10'd102;
        step();
        check_eq("space_ok", bus.gnt, 4'b0010);
        bus.req[1] = 1'b0;
        src_wr(1, 1'b1, 1'b1, 32'h0000_0404);
        step();
        src_idle();
        step();

        // not-ready gating
        bus.tx_ready = 1'b0;
        bus.req[2]   = 1'b1;
        repeat (4) step();
        check_eq("rdy_blk", bus.gnt, 0);
        bus.tx_ready = 1'b1;
        step();
        check_eq("rdy_ok", bus.gnt, 4'b0100);
        bus.req[2] = 1'b0;
        src_wr(2, 1'b1, 1'b1, 32'h0000_0202);
        step();
        src_idle();
        step();

        // watchdog: granted source never writes
        bus.req[3] = 1'b1;
        wait_gnt(10, cyc);
        check_eq("wd_gnt", bus.gnt, 4'b1000);
        bus.req[3] = 1'b0;
        cyc = 0;
        saw = 1'b0;
        while (bus.gnt != '0 && cyc < 40) begin
            step();
            cyc++;
            if (bus.tx_end || bus.tx_we) saw = 1'b1;
        end
        check_eq("wd_cycles", cyc, 16);
        check_eq("wd_flag", err_wdog, 1);
        check_eq("wd_no_end", saw, 0);
        check_eq("wd_no_proto", err_proto, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("wd_clr", err_wdog, 0);

        // stray write from a non-granted source
        bus.req_len[15:0] = 16'd8;
        bus.req[0]        = 1'b1;
        wait_gnt(10, cyc);
        check_eq("pr_gnt", bus.gnt, 4'b0001);
        bus.req[0] = 1'b0;
        src_idle();
        bus.src_we[2]        = 1'b1;
        bus.src_data[95:64]  = 32'hDEAD_BEEF;
        #1;
        check_eq("pr_stray_we", bus.tx_we, 0);
        check_eq("pr_stray_data", bus.tx_data, 0);
        step();
        check_eq("pr_stray_flag", err_proto, 1);
        src_wr(0, 1'b1, 1'b1, 32'hC0DE_0001);
        #1;
        check_eq("pr_legit_we", bus.tx_we, 1);
        step();
        src_idle();
        check_eq("pr_legit_rel", bus.gnt, 0);
        bus.src_we[1] = 1'b1;
        err_clr       = 1'b1;
        step();
        src_idle();
        err_clr = 1'b0;
        check_eq("pr_set_beats_clr", err_proto, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("pr_clr", err_proto, 0);

        // first granted write without START
        bus.req_len[31:16] = 16'd0;
        bus.req[1]         = 1'b1;
        wait_gnt(10, cyc);
        check_eq("ns_gnt", bus.gnt, 4'b0010);
        bus.req[1] = 1'b0;
        src_wr(1, 1'b0, 1'b0, 32'h1234_5678);
        #1;
        check_eq("ns_we", bus.tx_we, 0);
        step();
        src_idle();
        check_eq("ns_flag", err_proto, 1);
        src_wr(1, 1'b1, 1'b1, 32'h1234_0001);
        #1;
        check_eq("ns_legit_we", bus.tx_we, 1);
        step();
        src_idle();
        check_eq("ns_rel", bus.gnt, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();

        // reset mid-frame, then source 0 wins first
        bus.req[2] = 1'b1;
        wait_gnt(10, cyc);
        check_eq("mr_gnt", bus.gnt, 4'b0100);
        bus.req[2] = 1'b0;
        src_wr(2, 1'b1, 1'b0, 32'h0000_F00D);
        #1;
        check_eq("mr_we_pre", bus.tx_we, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_gnt_rst", bus.gnt, 0);
        check_eq("mr_we_rst", bus.tx_we, 0);
        check_eq("mr_busy_rst", busy, 0);
        step();
        rst_n = 1'b1;
        src_idle();
        bus.req = 4'b0101;
        wait_gnt(10, cyc);
        check_eq("mr_first", bus.gnt, 4'b0001);
        bus.req = '0;
        src_wr(0, 1'b1, 1'b1, 32'h0000_0001);
        step();
        src_idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/aq_gemac_tx_arbiter.md
Name: aq_gemac_tx_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares the single Ethernet-MAC TX buffer write port between NREQ frame sources (UDP controller, ARP/ICMP responders, external host path).
- Each source requests with a byte length. The arbiter grants only when the buffer is ready and has room for the whole frame.
- While granted, the source's write stream passes through to the buffer untouched until its END word.
- Sits between the protocol controllers and the MAC TX buffer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WDOG, 4096, cycles a granted source may stay idle (no WE) before its grant is revoked.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- REQ  in  NREQ  per-source frame request, held until GNT
- REQ_LEN  in  16*NREQ  per-source frame length in bytes (slice i = [16i+15:16i])
- GNT  out  NREQ  one-hot grant, registered
- SRC_WE  in  NREQ  per-source write enable
- SRC_START  in  NREQ  per-source first-word flag
- SRC_END  in  NREQ  per-source last-word flag
- SRC_DATA  in  32*NREQ  per-source write data
- TX_WE  out  1  to MAC buffer
- TX_START  out  1  to MAC buffer
- TX_END  out  1  to MAC buffer
- TX_DATA  out  32  to MAC buffer
- TX_READY  in  1  MAC buffer ready
- TX_FULL  in  1  MAC buffer full (broadcast to sources, not gated)
- TX_SPACE  in  10  free space in 32-bit words
- BUSY  out  1  state != A_IDLE
- ERR_WDOG  out  1  sticky watchdog-revoke flag
- ERR_PROTO  out  1  sticky protocol-violation flag
- ERR_CLR  in  1  clears both sticky flags

Behaviour:
- Reset values:
  - state A_IDLE, GNT=0, rr pointer=NREQ-1.
  - TX_WE/TX_START/TX_END=0, TX_DATA=0.
  - ERR_WDOG=ERR_PROTO=0, idle counter=0.
- State A_IDLE:
  - If any REQ, pick the winner by rotating priority starting at (ptr+1) mod NREQ.
  - Latch winner index and need = REQ_LEN + 4, computed in 17 bits (length word included); REQ_LEN=0 gives need=4.
  - Go to A_CHECK.
- State A_CHECK:
  - If REQ[idx] has dropped, return to A_IDLE with no grant and ptr unchanged.
  - Else if TX_READY && {5'd0,TX_SPACE,2'd0} > need, go to A_GRANT and set GNT[idx]=1 in the same edge.
  - Else stay in A_CHECK. There is no re-arbitration while waiting, so a large frame cannot be starved by small ones.
- State A_GRANT:
  - TX_WE/START/END/DATA = SRC_*[idx], combinational mux; when no grant, outputs are 0.
  - Leave on the cycle SRC_WE[idx] && SRC_END[idx] → A_RELEASE.
  - Single-word frames (START and END together) are legal.
- State A_RELEASE: GNT=0, ptr=idx, go to A_IDLE. Grant-to-grant minimum gap is 3 cycles.
- Watchdog:
  - In A_GRANT, the counter increments each cycle without SRC_WE[idx] and clears on any SRC_WE[idx].
  - On reaching WDOG-1: drop GNT, set ERR_WDOG, go to A_RELEASE.
  - No TX_END is synthesised; the MAC buffer discards the partial frame when the next TX_START arrives.
- Protocol violations: each sets ERR_PROTO and is not forwarded.
  - Any SRC_WE[j] with j not granted.
  - First granted write without SRC_START.
  - A second SRC_START within the same grant (the write itself is forwarded).
- ERR_CLR has priority below a same-cycle set, so the flag stays 1.
- TX_FULL is ignored by the arbiter; sources must throttle themselves.
- Reset mid-frame: outputs drop to 0 asynchronously; no TX_END is issued.

Decomposition:
- Package aq_gemac_pkg holds:
  - arbiter state encodings A_IDLE=0, A_CHECK=1, A_GRANT=2, A_RELEASE=3;
  - constant FRAME_HDR_BYTES=4 (length word).
- One sub-module, aq_gemac_rr_pick: combinational rotating-priority encoder. Inputs are the REQ vector and ptr; outputs are the winner index and a valid flag. It is reused by the RX-side dispatcher.

Test Plan:
- Single source: REQ[0]=1, REQ_LEN=64, TX_SPACE=100, TX_READY=1 → GNT[0] rises 2 cycles after REQ. 17 words with START on the first and END on the last appear on TX_* unchanged; GNT falls 1 cycle after END.
- Round robin: REQ=4'b1111 held, each source sends 1 word → grant order 0,1,2,3,0 with a 3-cycle gap between grants.
- Space gating: REQ_LEN=400, TX_SPACE=101 (404 bytes, not > 404) → no grant. Raise TX_SPACE to 102 → GNT the next cycle. TX_READY=0 also blocks the grant.
- Watchdog: WDOG=16, source granted but never writes → GNT drops after 16 cycles, ERR_WDOG=1, no TX_END emitted. ERR_CLR → 0.
- Protocol: non-granted SRC_WE[2] during grant 0 → TX_* unaffected, ERR_PROTO=1. Separately, granted first write without START → ERR_PROTO=1.
- Reset in A_GRANT mid-frame → GNT=0 and TX_WE=0 immediately. After release, ptr=NREQ-1 and source 0 wins first.
